// File: rtl/alu_operand_serializer.sv
// ---------------------------------------------------------------------------
// alu_operand_serializer
//
// Bit-serial transmitter feeding the fault-tolerant ALU's DATA_IN/Ready pair.
// A START while idle captures {OPCODE, A, B} (plus an optional even-parity
// bit) into a frame register. The frame is then shifted out MSB-first, one
// bit per clock, on DATA_OUT, with READY_OUT qualifying every frame bit.
//
// The control state is triple-redundant: the FSM state, the bit counter and
// the gap counter each exist as three copies. Next-state logic only ever
// sees the bitwise majority of the copies. All copies are rewritten from the
// voted next value every cycle, so a single-copy upset is scrubbed on the
// following edge. Any disagreement between a copy and its vote sets the
// sticky SEU_FLAG.
//
// All outputs are registered from the voted current state. They therefore
// lag the internal FSM by one cycle: for a START sampled at edge k, bit 0
// appears after edge k+1 and DONE after edge k+FRAME_LEN+1.
//
// Parameters
//   DW          operand width (A and B)
//   OP_W        opcode width
//   PARITY_EN   1 = append one even-parity bit to each frame
//   GAP_CYCLES  idle cycles after a frame before the next START is taken
//
// Ports
//   CLK        clock, rising edge
//   RST        asynchronous active-high reset
//   START      frame request, honoured only while idle
//   OPCODE     opcode, sampled on the accepting edge
//   A, B       operands, sampled on the accepting edge
//   CLR_FLAG   synchronous clear of SEU_FLAG (a coincident set wins)
//   DATA_OUT   serial data bit (0 outside frames)
//   READY_OUT  high exactly while DATA_OUT carries a frame bit
//   BUSY       high while a frame or its trailing gap is in progress
//   DONE       one-cycle pulse right after the last frame bit
//   SEU_FLAG   sticky redundancy-disagreement flag
// ---------------------------------------------------------------------------
module alu_operand_serializer #(
    parameter int unsigned DW         = 16,
    parameter int unsigned OP_W       = 4,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic [OP_W-1:0] OPCODE,
    input  logic [DW-1:0]   A,
    input  logic [DW-1:0]   B,
    input  logic            CLR_FLAG,
    output logic            DATA_OUT,
    output logic            READY_OUT,
    output logic            BUSY,
    output logic            DONE,
    output logic            SEU_FLAG
);

    localparam int unsigned PAYLOAD_LEN = OP_W + 2 * DW;
    localparam int unsigned FRAME_LEN   = PAYLOAD_LEN + ((PARITY_EN != 0) ? 1 : 0);
    localparam int unsigned CW = ($clog2(FRAME_LEN) > 0) ? $clog2(FRAME_LEN) : 1;
    localparam int unsigned GW = ($clog2(GAP_CYCLES + 1) > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);
    // With no gap the GAP state is unreachable; keep the constant well-formed.
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSend = 2'd1,
        StGap  = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Redundant control state (three copies each)
    // ------------------------------------------------------------------
    state_e        state0_q, state1_q, state2_q;
    logic [CW-1:0] cnt0_q, cnt1_q, cnt2_q;
    logic [GW-1:0] gap0_q, gap1_q, gap2_q;

    // Single-copy datapath and registered outputs
    logic [FRAME_LEN-1:0] frame_q, frame_d;
    logic                 data_out_q, data_out_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 seu_q, seu_d;

    // Voted values and next state
    logic [1:0]    state_bits;
    state_e        state_v, state_d;
    logic [CW-1:0] cnt_v, cnt_d;
    logic [GW-1:0] gap_v, gap_d;
    logic          mismatch;
    logic [CW-1:0] bit_idx;

    // ------------------------------------------------------------------
    // Frame assembly: OPCODE, A, B MSB-first, then optional parity
    // ------------------------------------------------------------------
    logic [PAYLOAD_LEN-1:0] payload;
    logic [FRAME_LEN-1:0]   frame_load;

    assign payload = {OPCODE, A, B};

    if (PARITY_EN != 0) begin : g_parity
        // Even parity: total number of ones in the frame is even.
        assign frame_load = {payload, ^payload};
    end else begin : g_no_parity
        assign frame_load = payload;
    end

    // ------------------------------------------------------------------
    // Majority voting and disagreement detection
    // ------------------------------------------------------------------
    always_comb begin
        state_bits = (state0_q & state1_q) | (state0_q & state2_q) | (state1_q & state2_q);
        // The 2'b11 encoding can only arise from a multi-copy upset; fall
        // back to idle rather than inventing a state.
        case (state_bits)
            2'd1:    state_v = StSend;
            2'd2:    state_v = StGap;
            default: state_v = StIdle;
        endcase

        cnt_v = (cnt0_q & cnt1_q) | (cnt0_q & cnt2_q) | (cnt1_q & cnt2_q);
        gap_v = (gap0_q & gap1_q) | (gap0_q & gap2_q) | (gap1_q & gap2_q);

        mismatch = (state0_q != state_v) || (state1_q != state_v) || (state2_q != state_v) ||
                   (cnt0_q != cnt_v) || (cnt1_q != cnt_v) || (cnt2_q != cnt_v) ||
                   (gap0_q != gap_v) || (gap1_q != gap_v) || (gap2_q != gap_v);
    end

    // ------------------------------------------------------------------
    // Next-state logic (operates on voted values only)
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_v;
        cnt_d   = cnt_v;
        gap_d   = gap_v;
        frame_d = frame_q;

        case (state_v)
            StIdle: begin
                if (START) begin
                    frame_d = frame_load;
                    cnt_d   = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (cnt_v == CNT_LAST) begin
                    cnt_d = '0;
                    gap_d = '0;
                    if (GAP_CYCLES > 0) begin
                        state_d = StGap;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_v + 1'b1;
                end
            end
            StGap: begin
                if (gap_v == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = StIdle;
                end else begin
                    gap_d = gap_v + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output next values, registered from the voted current state
    // ------------------------------------------------------------------
    always_comb begin
        bit_idx    = CNT_LAST - cnt_v;
        ready_d    = (state_v == StSend);
        data_out_d = ready_d ? frame_q[bit_idx] : 1'b0;
        busy_d     = (state_v != StIdle);
        // The cycle after the last bit is the first one whose voted state is
        // no longer SEND while the previous output was still a frame bit.
        done_d     = ready_q && (state_v != StSend);
        // Set dominates clear.
        seu_d      = mismatch || (seu_q && !CLR_FLAG);
    end

    // ------------------------------------------------------------------
    // State registers; every copy is rewritten from the vote (scrubbing)
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state0_q   <= StIdle;
            state1_q   <= StIdle;
            state2_q   <= StIdle;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
            cnt2_q     <= '0;
            gap0_q     <= '0;
            gap1_q     <= '0;
            gap2_q     <= '0;
            frame_q    <= '0;
            data_out_q <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            seu_q      <= 1'b0;
        end else begin
            state0_q   <= state_d;
            state1_q   <= state_d;
            state2_q   <= state_d;
            cnt0_q     <= cnt_d;
            cnt1_q     <= cnt_d;
            cnt2_q     <= cnt_d;
            gap0_q     <= gap_d;
            gap1_q     <= gap_d;
            gap2_q     <= gap_d;
            frame_q    <= frame_d;
            data_out_q <= data_out_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            seu_q      <= seu_d;
        end
    end

    assign DATA_OUT  = data_out_q;
    assign READY_OUT = ready_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign SEU_FLAG  = seu_q;

endmodule

// File: tb/tb_alu_operand_serializer.sv
// ---------------------------------------------------------------------------
// Bench for alu_operand_serializer. Two instances: dut0 with defaults
// (37-bit frames, parity, one gap cycle) and dut1 with PARITY_EN=0 and
// GAP_CYCLES=0 (36-bit frames, back-to-back). Stimulus pushes the
// hand-computed frame bits into a per-instance queue; a monitor per instance
// pops and compares whenever READY_OUT is high, and also checks frame length
// and the DONE pulse position.
// ---------------------------------------------------------------------------
module tb_alu_operand_serializer;

    localparam int unsigned FL0 = 37;
    localparam int unsigned FL1 = 36;

    // Hand-computed frames: {opcode, A, B, parity}
    localparam logic [36:0] F0 = {4'hA, 16'h1234, 16'hFFFF, 1'b1};
    localparam logic [36:0] F1 = {4'h5, 16'h8001, 16'h00F0, 1'b0};
    localparam logic [36:0] F2 = {4'hF, 16'hAAAA, 16'h5555, 1'b0};
    localparam logic [36:0] F3 = {4'h1, 16'h0000, 16'h0001, 1'b0};
    localparam logic [36:0] F4 = {4'h3, 16'h0007, 16'h0000, 1'b1};
    localparam logic [35:0] G0 = 36'h0;
    localparam logic [35:0] G1 = {4'h9, 16'h0F0F, 16'hC003};

    logic CLK = 1'b0;
    logic RST = 1'b1;

    logic        start0 = 1'b0, clr0 = 1'b0;
    logic [3:0]  op0 = '0;
    logic [15:0] a0 = '0, b0 = '0;
    logic        d0, r0, busy0, done0, seu0;

    logic        start1 = 1'b0, clr1 = 1'b0;
    logic [3:0]  op1 = '0;
    logic [15:0] a1 = '0, b1 = '0;
    logic        d1, r1, busy1, done1, seu1;

    int errors = 0;
    int checks = 0;

    bit exp0_q[$];
    bit exp1_q[$];

    logic rdy_h  [200];
    logic busy_h [200];
    logic done_h [200];

    always #5 CLK = ~CLK;

    alu_operand_serializer dut0 (
        .CLK(CLK), .RST(RST), .START(start0), .OPCODE(op0), .A(a0), .B(b0),
        .CLR_FLAG(clr0), .DATA_OUT(d0), .READY_OUT(r0), .BUSY(busy0), .DONE(done0),
        .SEU_FLAG(seu0)
    );

    alu_operand_serializer #(
        .DW(16), .OP_W(4), .PARITY_EN(0), .GAP_CYCLES(0)
    ) dut1 (
        .CLK(CLK), .RST(RST), .START(start1), .OPCODE(op1), .A(a1), .B(b1),
        .CLR_FLAG(clr1), .DATA_OUT(d1), .READY_OUT(r1), .BUSY(busy1), .DONE(done1),
        .SEU_FLAG(seu1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push0(input logic [36:0] f);
        for (int i = 36; i >= 0; i--) exp0_q.push_back(f[i]);
    endtask

    task automatic push1(input logic [35:0] f);
        for (int i = 35; i >= 0; i--) exp1_q.push_back(f[i]);
    endtask

    // Drive a START request at the next falling edge; the following rising
    // edge is the accepting edge k.
    task automatic drive(input int id, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b);
        @(negedge CLK);
        if (id == 0) begin
            op0 = op; a0 = a; b0 = b; start0 = 1'b1;
        end else begin
            op1 = op; a1 = a; b1 = b; start1 = 1'b1;
        end
    endtask

    // Record outputs at n falling edges; index m is the edge after k+m.
    task automatic capture(input int id, input int n, input int drop_at);
        for (int m = 0; m < n; m++) begin
            @(negedge CLK);
            if (m == drop_at) begin
                if (id == 0) start0 = 1'b0;
                else start1 = 1'b0;
            end
            rdy_h[m]  = (id == 0) ? r0 : r1;
            busy_h[m] = (id == 0) ? busy0 : busy1;
            done_h[m] = (id == 0) ? done0 : done1;
        end
    endtask

    function automatic int count_rdy(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += int'(rdy_h[i]);
        return s;
    endfunction

    function automatic int count_done(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += int'(done_h[i]);
        return s;
    endfunction

    // ---------------- monitors ----------------
    initial begin
        logic prev = 1'b0;
        int   run  = 0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev = 1'b0;
                run  = 0;
            end else begin
                if (r0) begin
                    run++;
                    check("dut0 bit expected", exp0_q.size() > 0, 1);
                    if (exp0_q.size() > 0) check("dut0 DATA_OUT", d0, exp0_q.pop_front());
                end else begin
                    check("dut0 DATA_OUT idle", d0, 0);
                end
                if (prev && !r0) begin
                    check("dut0 frame length", run, FL0);
                    check("dut0 DONE after last bit", done0, 1);
                    run = 0;
                end else if (done0) begin
                    check("dut0 stray DONE", done0, 0);
                end
                prev = r0;
            end
        end
    end

    initial begin
        logic prev = 1'b0;
        int   run  = 0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev = 1'b0;
                run  = 0;
            end else begin
                if (r1) begin
                    run++;
                    check("dut1 bit expected", exp1_q.size() > 0, 1);
                    if (exp1_q.size() > 0) check("dut1 DATA_OUT", d1, exp1_q.pop_front());
                end
                if (prev && !r1) begin
                    check("dut1 frame length", run, FL1);
                    check("dut1 DONE after last bit", done1, 1);
                    run = 0;
                end else if (done1) begin
                    check("dut1 stray DONE", done1, 0);
                end
                prev = r1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(negedge CLK);
        check("reset dut0 outputs", {d0, r0, busy0, done0, seu0}, 5'b0);
        check("reset dut1 outputs", {d1, r1, busy1, done1, seu1}, 5'b0);
        @(negedge CLK);
        #2 RST = 1'b0;
        repeat (2) @(negedge CLK);
        check("idle dut0 outputs", {d0, r0, busy0, done0, seu0}, 5'b0);

        // 1: single frame, default parameters
        drive(0, 4'hA, 16'h1234, 16'hFFFF);
        push0(F0);
        capture(0, 41, 0);
        check("t1 ready before bit0", rdy_h[0], 0);
        check("t1 ready at bit0", rdy_h[1], 1);
        check("t1 busy at bit0", busy_h[1], 1);
        check("t1 ready at last bit", rdy_h[37], 1);
        check("t1 ready after frame", rdy_h[38], 0);
        check("t1 done position", done_h[38], 1);
        check("t1 busy during gap", busy_h[38], 1);
        check("t1 busy falls", busy_h[39], 0);
        check("t1 ready count", count_rdy(41), 37);
        check("t1 done count", count_done(41), 1);

        // 2: START held high across two acceptances
        drive(0, 4'h5, 16'h8001, 16'h00F0);
        push0(F1);
        push0(F1);
        capture(0, 80, 39);
        check("t2 ready low gap a", rdy_h[38], 0);
        check("t2 ready low gap b", rdy_h[39], 0);
        check("t2 second frame start", rdy_h[40], 1);
        check("t2 second frame end", rdy_h[76], 1);
        check("t2 after second frame", rdy_h[77], 0);
        check("t2 ready count", count_rdy(80), 74);
        check("t2 done count", count_done(80), 2);

        // 3: inputs scrambled and START pulsed while the frame is in flight
        drive(0, 4'hF, 16'hAAAA, 16'h5555);
        push0(F2);
        for (int m = 0; m < 46; m++) begin
            @(negedge CLK);
            op0 = 4'($urandom);
            a0  = 16'($urandom);
            b0  = 16'($urandom);
            start0 = (m == 5 || m == 20);
            rdy_h[m] = r0;
        end
        check("t3 ready count", count_rdy(46), 37);
        check("t3 queue drained", exp0_q.size(), 0);

        // 4: reset at bit 10, then a full frame
        drive(0, 4'h1, 16'h0000, 16'h0001);
        push0(F3);
        for (int m = 0; m < 12; m++) begin
            @(negedge CLK);
            if (m == 0) start0 = 1'b0;
        end
        check("t4 mid-frame ready", r0, 1);
        #2 RST = 1'b1;
        #1 check("t4 async reset outputs", {d0, r0, busy0, done0, seu0}, 5'b0);
        exp0_q.delete();
        @(negedge CLK);
        @(negedge CLK);
        check("t4 no done in reset", done0, 0);
        #2 RST = 1'b0;
        drive(0, 4'h3, 16'h0007, 16'h0000);
        push0(F4);
        capture(0, 41, 0);
        check("t4 ready count after reset", count_rdy(41), 37);
        check("t4 done count after reset", count_done(41), 1);

        // 5: single-copy counter upset mid-frame
        check("t5 flag clear before", seu0, 0);
        drive(0, 4'hA, 16'h1234, 16'hFFFF);
        push0(F0);
        for (int m = 0; m < 41; m++) begin
            @(negedge CLK);
            if (m == 0) start0 = 1'b0;
            if (m == 15) force dut0.cnt1_q = 6'd33;
            if (m == 16) release dut0.cnt1_q;
            if (m == 17) check("t5 flag set", seu0, 1);
            rdy_h[m] = r0;
        end
        check("t5 ready count", count_rdy(41), 37);
        check("t5 flag sticky", seu0, 1);
        clr0 = 1'b1;
        @(negedge CLK);
        clr0 = 1'b0;
        check("t5 flag cleared", seu0, 0);

        // 6: dut1, no parity, zero operands
        drive(1, 4'h0, 16'h0000, 16'h0000);
        push1(G0);
        capture(1, 40, 0);
        check("t6 ready count", count_rdy(40), 36);
        check("t6 done count", count_done(40), 1);

        // 7: dut1 back-to-back frames with START held
        drive(1, 4'h9, 16'h0F0F, 16'hC003);
        push1(G1);
        push1(G1);
        capture(1, 76, 37);
        check("t7 first frame end", rdy_h[36], 1);
        check("t7 single low cycle", rdy_h[37], 0);
        check("t7 second frame start", rdy_h[38], 1);
        check("t7 ready count", count_rdy(76), 72);
        check("t7 done count", count_done(76), 2);

        @(negedge CLK);
        check("dut0 queue drained", exp0_q.size(), 0);
        check("dut1 queue drained", exp1_q.size(), 0);
        check("dut1 flag clear", seu1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
